sha256_hash_scanner: RTL and testbench
======================================

// Module: sha256_hash_scanner
// PURPOSE
// - Consumer of the hash table the bitcoin hash engine writes to memory. It reads the 8-word SHA-256 results
//   stored at hash_addr + 8*n for every nonce n, then compares each one against a 256-bit target read from memory.
// - Reports the first nonce whose hash is strictly below the target, plus the total hit count.
// - Shares the engine's single-port memory interface (sync read, 1-cycle latency); runs after the engine's done.
// PARAMETERS
// - NUM_NONCES  16  number of consecutive 8-word hash entries to scan (1..256)
// PORTS
// - clk             in   1    clock; mem_clk is driven directly from it
// - reset_n         in   1    asynchronous, active-low reset
// - start           in   1    begin scan; sampled only in IDLE
// - hash_addr       in   16   word address of nonce-0 hash word 0 (most significant word)
// - target_addr     in   16   word address of 8-word target, word 0 most significant
// - result_addr     in   16   word address for result writeback (used only with macro)
// - done            out  1    high while in IDLE
// - found           out  1    at least one hash < target in last scan
// - nonce_out       out  8    lowest nonce with hash < target; 0 if !found
// - hit_count       out  9    number of nonces with hash < target
// - mem_clk         out  1    = clk
// - mem_we          out  1    write enable
// - mem_addr        out  16   word address
// - mem_write_data  out  32   write data
// - mem_read_data   in   32   read data; valid the cycle after mem_addr is presented
// BEHAVIOUR
// - Reset: state IDLE, done=1, found=0, nonce_out=0, hit_count=0, mem_we=0, mem_addr=0, mem_write_data=0.
// - Reset mid-scan aborts immediately and applies the same values; no partial writeback.
// - IDLE: on start, latch all three addresses, clear found/nonce_out/hit_count, and go to READ. done drops the next cycle.
// - start while not IDLE is ignored. Address inputs are don't-care after being latched.
// - READ: issue one read per cycle, back to back.
//   - First issue target_addr+0..7, then hash_addr+0..8*NUM_NONCES-1. 16-bit address wrap is allowed.
//   - Data is captured one cycle after issue, so there are 8+8*NUM_NONCES issue cycles followed by 1 drain cycle.
// - Target words go into tgt[0..7]. Each hash word k of nonce n is compared against tgt[k] via a streaming compare:
//   - The compare state is reset to EQ at k=0.
//   - While EQ: word < tgt moves to LT, word > tgt moves to GT.
//   - LT and GT are sticky for the rest of the entry.
//   - At k=7, after the final word is applied, LT counts as a hit. EQ counts as a miss (strictly less required).
// - On a hit: hit_count+1. If found was 0, set found=1 and nonce_out=n (first hit wins).
// - All words are unsigned 32-bit. hit_count saturates at NUM_NONCES (it cannot overflow at width 9).
// - After the last captured word, go to WRITE if the macro is defined, else IDLE.
// - Latency, start-sample edge to done=1: 8*NUM_NONCES+10 cycles, or +2 cycles with the macro.
// - found, nonce_out and hit_count hold their values until the next start or reset.
// - mem_we=0 in all states except WRITE.
// CONFIGURATION
// - SHA256_SCAN_WRITEBACK_EN defined: WRITE state, 2 cycles, mem_we=1.
//   - Cycle 1 writes {31'b0,found} to result_addr+0.
//   - Cycle 2 writes {15'b0,hit_count,nonce_out} to result_addr+1.
//   - Then go to IDLE.
// - Not defined: no WRITE state, mem_we tied 0, result_addr ignored.
// STRUCTURE
// - Package sha256_scan_pkg holds:
//   - state enum {IDLE, READ, WRITE}
//   - cmp_t enum {CMP_EQ, CMP_LT, CMP_GT}
//   - localparam WORDS_PER_HASH=8
// - Sub-module hash_word_cmp: streaming 32-bit comparator with a sticky cmp_t state and a clear on k=0.
// - The top level holds the FSM, the address counter, the 8x32 target register and the result registers.
// TESTING
// - NUM_NONCES=4, target=8x FFFFFFFF, hashes all 0 -> found=1, nonce_out=0, hit_count=4, done after 42 cycles.
// - target word0=00001000 with rest 0; nonce2 word0=00000FFF, others word0=00002000
//   -> found=1, nonce_out=2, hit_count=1.
// - Hash exactly equal to target for every nonce -> found=0, nonce_out=0, hit_count=0 (strictly-less check).
// - Target word0..6 equal to hash words; nonce3 word7=target word7-1 -> hit only at nonce 3.
//   Checks late-word decision and sticky GT on other entries.
// - Assert reset_n=0 at cycle 20 of a scan -> done=1, found=0, mem_we=0 at once.
//   A new start then completes a normal scan.
// - With SHA256_SCAN_WRITEBACK_EN, result_addr=0x0100 and a hit at nonce 1 of 4
//   -> mem[0x100]=1, mem[0x101]=0x00000101; no other writes seen.

Source files
------------

// File: rtl/sha256_scan_pkg.sv
// Shared types for the SHA-256 hash-table scanner: FSM states, streaming compare result,
// and the number of 32-bit words per hash/target entry.
package sha256_scan_pkg;
    localparam int WORDS_PER_HASH = 8;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_t;
endpackage

// File: rtl/hash_word_cmp.sv
// Streaming MSW-first 256-bit magnitude compare, one 32-bit word per enabled cycle;
// cmp_next is the verdict including the current word, no backpressure.
module hash_word_cmp
    import sha256_scan_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        first,
    input  logic [31:0] word,
    input  logic [31:0] tgt_word,
    output cmp_t        cmp_next
);
    cmp_t cmp_state;
    cmp_t base;

    // The first word of an entry ignores whatever the previous entry left behind.
    always_comb begin
        base     = first ? CMP_EQ : cmp_state;
        cmp_next = base;
        if (base == CMP_EQ) begin
            if (word < tgt_word)
                cmp_next = CMP_LT;
            else if (word > tgt_word)
                cmp_next = CMP_GT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cmp_state <= CMP_EQ;
        else if (en)
            cmp_state <= cmp_next;
    end
endmodule

// File: rtl/sha256_hash_scanner.sv
// Scans NUM_NONCES 8-word hashes against a 256-bit target over a sync single-port memory; done after
// 8*NUM_NONCES+10 cycles (+2 writeback cycles when SHA256_SCAN_WRITEBACK_EN is defined), no backpressure.
module sha256_hash_scanner
    import sha256_scan_pkg::*;
#(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] target_addr,
    input  logic [15:0] result_addr,
    output logic        done,
    output logic        found,
    output logic [7:0]  nonce_out,
    output logic [8:0]  hit_count,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    localparam int          NUM_WORDS = WORDS_PER_HASH * (NUM_NONCES + 1);
    localparam logic [11:0] ISSUE_END = 12'(NUM_WORDS);
    localparam logic [11:0] CAP_LAST  = 12'(NUM_WORDS + 1);
    localparam logic [8:0]  HIT_MAX   = 9'(NUM_NONCES);

    state_t      state, state_nxt;
    logic [11:0] cnt;
    logic [15:0] hash_base, tgt_base, rd_addr;
    logic [31:0] tgt [WORDS_PER_HASH];
    logic [11:0] widx;
    logic [2:0]  k;
    logic [7:0]  cap_nonce;
    logic        cap_vld, cap_tgt, cap_hash, hit;
    cmp_t        cmp_next;

    // Registered address reaches memory one cycle after issue, data one cycle later.
    assign widx      = cnt - 12'd2;
    assign cap_vld   = (state == READ) && (cnt >= 12'd2);
    assign cap_tgt   = cap_vld && (widx < 12'(WORDS_PER_HASH));
    assign cap_hash  = cap_vld && !cap_tgt;
    assign k         = widx[2:0];
    assign cap_nonce = widx[10:3] - 8'd1;

    hash_word_cmp u_cmp (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (cap_hash),
        .first    (k == 3'd0),
        .word     (mem_read_data),
        .tgt_word (tgt[k]),
        .cmp_next (cmp_next)
    );

    assign hit = cap_hash && (k == 3'd7) && (cmp_next == CMP_LT);

`ifdef SHA256_SCAN_WRITEBACK_EN
    logic [15:0] res_base;
    logic        wr_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_base <= '0;
            wr_idx   <= 1'b0;
        end else begin
            if (state == IDLE && start)
                res_base <= result_addr;
            wr_idx <= (state == WRITE);
        end
    end
`else
    logic unused_result;
    assign unused_result = ^result_addr;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = READ;
            READ: if (cnt == CAP_LAST) begin
`ifdef SHA256_SCAN_WRITEBACK_EN
                state_nxt = WRITE;
`else
                state_nxt = IDLE;
`endif
            end
`ifdef SHA256_SCAN_WRITEBACK_EN
            WRITE: if (wr_idx) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            hash_base <= '0;
            tgt_base  <= '0;
            rd_addr   <= '0;
            found     <= 1'b0;
            nonce_out <= '0;
            hit_count <= '0;
        end else begin
            if (state == IDLE && start) begin
                cnt       <= '0;
                hash_base <= hash_addr;
                tgt_base  <= target_addr;
                found     <= 1'b0;
                nonce_out <= '0;
                hit_count <= '0;
            end
            if (state == READ) begin
                cnt <= cnt + 12'd1;
                if (cnt < ISSUE_END)
                    rd_addr <= (cnt < 12'(WORDS_PER_HASH)) ? tgt_base + 16'(cnt)
                                                           : hash_base + 16'(cnt - 12'(WORDS_PER_HASH));
            end
            if (hit) begin
                if (hit_count < HIT_MAX)
                    hit_count <= hit_count + 9'd1;
                if (!found) begin
                    found     <= 1'b1;
                    nonce_out <= cap_nonce;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_tgt)
            tgt[k] <= mem_read_data;
    end

    assign done    = (state == IDLE);
    assign mem_clk = clk;

    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = rd_addr;
        mem_write_data = '0;
`ifdef SHA256_SCAN_WRITEBACK_EN
        if (state == WRITE) begin
            mem_we         = 1'b1;
            mem_addr       = res_base + {15'b0, wr_idx};
            mem_write_data = wr_idx ? {15'b0, hit_count, nonce_out} : {31'b0, found};
        end
`endif
    end
endmodule

// File: tb/tb_sha256_hash_scanner.sv
// Randomised and directed scans of sha256_hash_scanner against a 256-bit integer compare model.
module tb_sha256_hash_scanner;
    localparam int NN = 4;
`ifdef SHA256_SCAN_WRITEBACK_EN
    localparam int EXP_LAT = 8 * NN + 12;
    localparam int EXP_WR  = 2;
`else
    localparam int EXP_LAT = 8 * NN + 10;
    localparam int EXP_WR  = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] hash_addr = '0, target_addr = '0, result_addr = '0;
    logic        done, found, mem_clk, mem_we;
    logic [7:0]  nonce_out;
    logic [8:0]  hit_count;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data, rd_q;

    logic [31:0] mem [65536];
    logic [15:0] res_base = 16'h0100;
    int          wr_cnt = 0, bad_wr = 0;
    int          n_pass = 0, n_total = 0;

    sha256_hash_scanner #(.NUM_NONCES(NN)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .hash_addr      (hash_addr),
        .target_addr    (target_addr),
        .result_addr    (result_addr),
        .done           (done),
        .found          (found),
        .nonce_out      (nonce_out),
        .hit_count      (hit_count),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (rd_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_q <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] = mem_write_data;
            wr_cnt++;
            if (mem_addr != res_base && mem_addr != res_base + 16'd1)
                bad_wr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic put(input logic [15:0] base, input int idx, input logic [31:0] v);
        logic [15:0] a;
        a = base + 16'(idx);
        mem[a] = v;
    endtask

    // Whole entries as 256-bit unsigned integers, word 0 most significant.
    task automatic model(input logic [15:0] h, input logic [15:0] t,
                         output logic f, output logic [7:0] nn, output logic [8:0] hc);
        logic [255:0] tv, hv;
        logic [15:0]  a;
        f = 1'b0; nn = '0; hc = '0; tv = '0; hv = '0;
        for (int i = 0; i < 8; i++) begin
            a  = t + 16'(i);
            tv = {tv[223:0], mem[a]};
        end
        for (int n = 0; n < NN; n++) begin
            for (int i = 0; i < 8; i++) begin
                a  = h + 16'(8 * n + i);
                hv = {hv[223:0], mem[a]};
            end
            if (hv < tv) begin
                if (!f) begin
                    f  = 1'b1;
                    nn = 8'(n);
                end
                hc++;
            end
        end
    endtask

    task automatic run_scan(input string tag, input logic [15:0] h, input logic [15:0] t, input bit poke);
        logic       f;
        logic [7:0] nn;
        logic [8:0] hc;
        int         lat, w0, b0;
        model(h, t, f, nn, hc);
        put(res_base, 0, 32'hDEADBEEF);
        put(res_base, 1, 32'hDEADBEEF);
        w0 = wr_cnt;
        b0 = bad_wr;
        @(negedge clk);
        hash_addr = h; target_addr = t; result_addr = res_base; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hash_addr = 16'($urandom); target_addr = 16'($urandom); result_addr = 16'($urandom);
        lat = 0;
        while (!done && lat < 4000) begin
            @(posedge clk);
            #1;
            lat++;
            start = (poke && lat == 15);
        end
        start = 1'b0;
        check({tag, "/latency"}, lat, EXP_LAT);
        check({tag, "/found"}, found, f);
        check({tag, "/nonce"}, nonce_out, nn);
        check({tag, "/hits"}, hit_count, hc);
        check({tag, "/writes"}, wr_cnt - w0, EXP_WR);
        check({tag, "/stray_writes"}, bad_wr - b0, 0);
`ifdef SHA256_SCAN_WRITEBACK_EN
        check({tag, "/wb0"}, mem[res_base], {31'b0, f});
        check({tag, "/wb1"}, mem[res_base + 16'd1], {15'b0, hc, nn});
`else
        check({tag, "/no_wb"}, mem[res_base], 32'hDEADBEEF);
`endif
    endtask

    task automatic fill_basic(input logic [15:0] h, input logic [15:0] t);
        for (int i = 0; i < 8; i++) put(t, i, 32'hFFFFFFFF);
        for (int i = 0; i < 8 * NN; i++) put(h, i, 32'h0);
    endtask

    logic [31:0] tw [8];
    logic [31:0] v;
    int          j;
    logic [15:0] hb, tb_addr;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        #2 reset_n = 1'b0;
        #10;
        check("rst/done", done, 1);
        check("rst/found", found, 0);
        check("rst/nonce", nonce_out, 0);
        check("rst/hits", hit_count, 0);
        check("rst/we", mem_we, 0);
        check("rst/addr", mem_addr, 0);
        check("rst/wdata", mem_write_data, 0);
        @(negedge clk) reset_n = 1'b1;

        // every hash below an all-ones target
        fill_basic(16'h0300, 16'h0200);
        run_scan("all_hit", 16'h0300, 16'h0200, 1'b0);

        // single hit decided on word 0
        for (int i = 0; i < 8; i++) put(16'h0200, i, (i == 0) ? 32'h00001000 : 32'h0);
        for (int n = 0; n < NN; n++)
            for (int i = 0; i < 8; i++)
                put(16'h0300, 8 * n + i, (i != 0) ? 32'h0 : (n == 2) ? 32'h00000FFF : 32'h00002000);
        run_scan("word0", 16'h0300, 16'h0200, 1'b0);

        // hit at nonce 1 only
        put(16'h0300, 16, 32'h00002000);
        put(16'h0300, 8, 32'h00000FFF);
        run_scan("nonce1", 16'h0300, 16'h0200, 1'b0);

        // equal hashes never count
        for (int i = 0; i < 8; i++) tw[i] = $urandom;
        for (int i = 0; i < 8; i++) put(16'h0200, i, tw[i]);
        for (int n = 0; n < NN; n++)
            for (int i = 0; i < 8; i++) put(16'h0300, 8 * n + i, tw[i]);
        run_scan("equal", 16'h0300, 16'h0200, 1'b0);

        // late-word decisions and sticky GT
        tw[3] = tw[3] & 32'h7FFFFFFF;
        tw[7] = 32'h80000000;
        for (int i = 0; i < 8; i++) put(16'h0200, i, tw[i]);
        for (int n = 0; n < NN; n++)
            for (int i = 0; i < 8; i++) put(16'h0300, 8 * n + i, tw[i]);
        put(16'h0300, 7, tw[7] + 32'd1);
        put(16'h0300, 8 + 3, tw[3] + 32'd1);
        put(16'h0300, 8 + 7, 32'h0);
        put(16'h0300, 24 + 7, tw[7] - 32'd1);
        run_scan("late", 16'h0300, 16'h0200, 1'b0);

        // random entries sharing a random-length prefix with the target
        for (int s = 0; s < 6; s++) begin
            hb      = (s == 0) ? 16'hFFF0 : 16'(16'h4000 + $urandom_range(0, 16'h3F00));
            tb_addr = 16'(16'h9000 + $urandom_range(0, 16'h0FF0));
            for (int i = 0; i < 8; i++) begin
                tw[i] = $urandom;
                put(tb_addr, i, tw[i]);
            end
            for (int n = 0; n < NN; n++) begin
                j = $urandom_range(0, 8);
                for (int i = 0; i < 8; i++) begin
                    if (i < j)
                        v = tw[i];
                    else if (i == j)
                        v = tw[i] + (($urandom_range(0, 1) == 1) ? 32'd1 : 32'hFFFFFFFF);
                    else
                        v = $urandom;
                    put(hb, 8 * n + i, v);
                end
            end
            run_scan($sformatf("rand%0d", s), hb, tb_addr, s == 2);
        end

        // abort mid-scan, then a clean scan
        fill_basic(16'h0300, 16'h0200);
        @(negedge clk);
        hash_addr = 16'h0300; target_addr = 16'h0200; result_addr = res_base; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("abort/pre_found", found, 1);
        reset_n = 1'b0;
        #1;
        check("abort/done", done, 1);
        check("abort/found", found, 0);
        check("abort/hits", hit_count, 0);
        check("abort/we", mem_we, 0);
        @(negedge clk) reset_n = 1'b1;
        run_scan("after_abort", 16'h0300, 16'h0200, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
